// File: rtl/regfile_pkg.sv
// Shared types for the integer register file write path: one queued writeback
// entry and the result of a forwarding lookup.
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } fwd_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries. Every slot is also exported in age
// order (index 0 = head) so the owner can search pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head_entry,
    output wb_entry_t                  entries [DEPTH],
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy is tracked directly; pointers only wrap as power-of-two counters.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + PW'(1);
        end
        if (do_pop) begin
            head_d = head_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem_q[head_q + PW'(i)];
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/regfile_writeback_queue.sv
// Register file write front end: arbitrates pipeline and multi-cycle writebacks
// into an in-order queue, drains one write per cycle and forwards pending data.
module regfile_writeback_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pipe_valid,
    input  logic [4:0]                 pipe_rd,
    input  logic [XLEN-1:0]            pipe_data,
    output logic                       pipe_stall,
    input  logic                       mc_valid,
    output logic                       mc_ready,
    input  logic [4:0]                 mc_rd,
    input  logic [XLEN-1:0]            mc_data,
    output logic                       reg_write,
    output logic [4:0]                 reg_rd,
    output logic [XLEN-1:0]            reg_wdata,
    input  logic [4:0]                 fwd_rs1,
    input  logic [4:0]                 fwd_rs2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [XLEN-1:0]            fwd_data1,
    output logic [XLEN-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import regfile_pkg::*;

    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    wb_entry_t        entries [DEPTH];
    logic             push;
    logic             pipe_acc;
    logic             mc_acc;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       reg_rd_q, reg_rd_d;
    logic [XLEN-1:0]  reg_wdata_q, reg_wdata_d;
    fwd_t             fwd1;
    fwd_t             fwd2;

    assign pipe_stall = full;
    assign mc_ready   = !reset && !pipe_valid && !full;
    assign pipe_acc   = pipe_valid && !full;
    assign mc_acc     = mc_valid && mc_ready;

    // x0 writes finish the handshake but are dropped before the queue.
    always_comb begin
        push_entry.rd   = pipe_valid ? pipe_rd : mc_rd;
        push_entry.data = pipe_valid ? pipe_data : mc_data;
        push            = (pipe_acc && pipe_rd != '0) || (mc_acc && mc_rd != '0);
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (!empty),
        .head_entry (head_entry),
        .entries    (entries),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        reg_write_d = !empty;
        reg_rd_d    = reg_rd_q;
        reg_wdata_d = reg_wdata_q;
        if (!empty) begin
            reg_rd_d    = head_entry.rd;
            reg_wdata_d = head_entry.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            reg_rd_q    <= '0;
            reg_wdata_q <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            reg_rd_q    <= reg_rd_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    function automatic fwd_t fwd_lookup(
        input logic [4:0]      rs,
        input wb_entry_t       ents [DEPTH],
        input logic [CW-1:0]   cnt,
        input logic            out_vld,
        input logic [4:0]      out_rd,
        input logic [XLEN-1:0] out_data
    );
        fwd_t r;
        r = '0;
        if (rs != '0) begin
            if (out_vld && out_rd == rs) begin
                r.hit  = 1'b1;
                r.data = out_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (i < int'(cnt) && ents[i].rd == rs) begin
                    r.hit  = 1'b1;
                    r.data = ents[i].data;
                end
            end
        end
        return r;
    endfunction

    assign fwd1 = fwd_lookup(fwd_rs1, entries, count, reg_write_q, reg_rd_q, reg_wdata_q);
    assign fwd2 = fwd_lookup(fwd_rs2, entries, count, reg_write_q, reg_rd_q, reg_wdata_q);

    assign fwd_hit1  = fwd1.hit;
    assign fwd_data1 = fwd1.data;
    assign fwd_hit2  = fwd2.hit;
    assign fwd_data2 = fwd2.data;

    assign reg_write = reg_write_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wdata = reg_wdata_q;

endmodule
